// File: rtl/wam_pkg.sv
// wam_pkg
// Shared types and constants for the whack-a-mole spawn scheduler.
//   state_t       : scheduler FSM states (IDLE, RUN, DRAIN)
//   diff_t        : one-hot difficulty encodings
//   diff_params_t : one row of the difficulty table (interval, lifetime, max_active)
//   diff_params() : maps a raw difficulty code to its table row; any code that is
//                   not one of the three one-hot values selects the default row
package wam_pkg;

  localparam int WAM_MS_W  = 11;
  localparam int WAM_HOLES = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIFF_EASY   = 3'b001,
    DIFF_MEDIUM = 3'b010,
    DIFF_HARD   = 3'b100
  } diff_t;

  localparam logic [WAM_MS_W-1:0] INTERVAL_EASY    = 11'd800;
  localparam logic [WAM_MS_W-1:0] INTERVAL_MEDIUM  = 11'd600;
  localparam logic [WAM_MS_W-1:0] INTERVAL_HARD    = 11'd400;
  localparam logic [WAM_MS_W-1:0] INTERVAL_DEFAULT = 11'd700;

  localparam logic [WAM_MS_W-1:0] LIFETIME_EASY    = 11'd1500;
  localparam logic [WAM_MS_W-1:0] LIFETIME_MEDIUM  = 11'd1200;
  localparam logic [WAM_MS_W-1:0] LIFETIME_HARD    = 11'd900;
  localparam logic [WAM_MS_W-1:0] LIFETIME_DEFAULT = 11'd1300;

  localparam logic [1:0] MAX_ACTIVE_EASY    = 2'd1;
  localparam logic [1:0] MAX_ACTIVE_MEDIUM  = 2'd2;
  localparam logic [1:0] MAX_ACTIVE_HARD    = 2'd3;
  localparam logic [1:0] MAX_ACTIVE_DEFAULT = 2'd1;

  // Spawn-ramp tuning: each block of 8 hits shortens the interval by this much,
  // never going below the floor.
  localparam logic [WAM_MS_W-1:0] RAMP_STEP_MS  = 11'd16;
  localparam logic [WAM_MS_W-1:0] RAMP_FLOOR_MS = 11'd200;

  typedef struct packed {
    logic [WAM_MS_W-1:0] interval;
    logic [WAM_MS_W-1:0] lifetime;
    logic [1:0]          max_active;
  } diff_params_t;

  function automatic diff_params_t diff_params(input logic [2:0] difficulty);
    diff_params_t p;
    case (difficulty)
      DIFF_EASY:   p = '{INTERVAL_EASY,    LIFETIME_EASY,    MAX_ACTIVE_EASY};
      DIFF_MEDIUM: p = '{INTERVAL_MEDIUM,  LIFETIME_MEDIUM,  MAX_ACTIVE_MEDIUM};
      DIFF_HARD:   p = '{INTERVAL_HARD,    LIFETIME_HARD,    MAX_ACTIVE_HARD};
      default:     p = '{INTERVAL_DEFAULT, LIFETIME_DEFAULT, MAX_ACTIVE_DEFAULT};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mole_hole_timer.sv
// mole_hole_timer
// Owns the occupancy bit and millisecond lifetime countdown of a single hole.
// Ports:
//   clk, reset_n : clock and async active-low reset
//   ms_tick      : 1-cycle pulse per millisecond
//   load         : spawn a mole here this cycle (only asserted for a free hole)
//   lifetime     : lifetime in ms loaded on spawn
//   kill         : mole whacked this cycle (wins over expiry)
//   occupied     : registered occupancy of this hole
//   expire       : combinational, high on the tick that ends the mole's life
module mole_hole_timer
  import wam_pkg::*;
#(
  parameter int MS_W = WAM_MS_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ms_tick,
  input  logic            load,
  input  logic [MS_W-1:0] lifetime,
  input  logic            kill,
  output logic            occupied,
  output logic            expire
);

  logic [MS_W-1:0] life_q;

  // The tick that would take the timer from 1 to 0 removes the mole instead.
  assign expire = occupied && ms_tick && (life_q == MS_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupied <= 1'b0;
      life_q   <= '0;
    end else if (kill) begin
      occupied <= 1'b0;
      life_q   <= '0;
    end else if (load) begin
      occupied <= 1'b1;
      life_q   <= lifetime;
    end else if (expire) begin
      occupied <= 1'b0;
      life_q   <= '0;
    end else if (occupied && ms_tick) begin
      life_q   <= life_q - MS_W'(1);
    end
  end

endmodule

// File: rtl/mole_spawn_scheduler.sv
// mole_spawn_scheduler
// Places moles onto the whack-a-mole holes, paces spawns by difficulty, caps the
// number of live moles, and turns switch presses into hit/miss pulses.
// Ports:
//   clk, reset_n   : clock and async active-low reset
//   ms_tick        : 1-cycle pulse per millisecond
//   start / stop   : begin round (IDLE only) / end round and drain (RUN only)
//   difficulty     : one-hot 001 easy, 010 medium, 100 hard, anything else default
//   random_value   : free-running pseudo-random value; low nibble picks the hole
//   switches       : synchronised whack switches, one per hole
//   mole_positions : occupied holes
//   hit_mask       : 1-cycle pulse, holes whacked while occupied
//   miss_mask      : 1-cycle pulse, holes whose mole expired unwhacked
//   active_count   : number of live moles
//   busy           : FSM not in IDLE
//   done           : 1-cycle pulse on the DRAIN->IDLE transition
// Build option: define WAM_SPAWN_RAMP_EN to shorten the spawn interval by 16 ms
// for every 8 hits in a round (floor 200 ms).
module mole_spawn_scheduler
  import wam_pkg::*;
#(
  parameter int N_HOLES = WAM_HOLES,
  parameter int MS_W    = WAM_MS_W,
  parameter int RAND_W  = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ms_tick,
  input  logic               start,
  input  logic               stop,
  input  logic [2:0]         difficulty,
  input  logic [RAND_W-1:0]  random_value,
  input  logic [N_HOLES-1:0] switches,
  output logic [N_HOLES-1:0] mole_positions,
  output logic [N_HOLES-1:0] hit_mask,
  output logic [N_HOLES-1:0] miss_mask,
  output logic [1:0]         active_count,
  output logic               busy,
  output logic               done
);

  localparam logic [3:0] HOLES4 = 4'(N_HOLES);
  localparam logic [4:0] HOLES5 = 5'(N_HOLES);

  state_t             state_q, state_d;
  logic               done_d;
  diff_params_t       params;
  logic [MS_W-1:0]    interval_eff;
  logic [MS_W-1:0]    spawn_cnt, cnt_inc;
  logic               spawn_fire, pick_found;
  logic [3:0]         cand;
  logic [N_HOLES-1:0] switches_q, sw_edge, hit_now, miss_now, expire_vec;
  logic [N_HOLES-1:0] pick_onehot, spawn_onehot, next_pos;
  logic [3:0]         next_count;
  logic               unused_rand;

  assign unused_rand = ^random_value[RAND_W-1:4];

  assign params = diff_params(difficulty);
  assign busy   = (state_q != IDLE);

`ifdef WAM_SPAWN_RAMP_EN
  logic [7:0]      hit_total;
  logic [3:0]      hit_now_cnt;
  logic [MS_W-1:0] ramp_cut;

  always_comb begin
    hit_now_cnt = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      hit_now_cnt = hit_now_cnt + 4'(hit_now[i]);
    end
  end

  // hit_total[7:3] counts completed blocks of 8 hits; each block is worth 16 ms.
  assign ramp_cut     = MS_W'({hit_total[7:3], 4'b0000});
  assign interval_eff = (params.interval > ramp_cut + RAMP_FLOOR_MS) ?
                        (params.interval - ramp_cut) : RAMP_FLOOR_MS;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_total <= '0;
    end else if (state_q == IDLE && start) begin
      hit_total <= '0;
    end else if (hit_total > 8'd255 - 8'(hit_now_cnt)) begin
      hit_total <= 8'd255;
    end else begin
      hit_total <= hit_total + 8'(hit_now_cnt);
    end
  end
`else
  assign interval_eff = params.interval;
`endif

  // Whacks only count on rising switch edges and only against live moles.
  assign sw_edge  = switches & ~switches_q;
  assign hit_now  = (state_q != IDLE) ? (sw_edge & mole_positions) : '0;
  assign miss_now = expire_vec & ~hit_now;

  // Counter saturates at the interval so a capped spawn fires on the first
  // tick after a slot frees up.
  assign cnt_inc = (spawn_cnt >= interval_eff) ? interval_eff : (spawn_cnt + MS_W'(1));

  assign cand = (random_value[3:0] >= HOLES4) ? (random_value[3:0] - HOLES4)
                                              : random_value[3:0];

  // Linear probe from the candidate hole, wrapping, against the registered
  // occupancy so a hole freed this cycle is not reused until the next spawn.
  always_comb begin
    logic [4:0] slot;
    slot        = '0;
    pick_found  = 1'b0;
    pick_onehot = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      slot = {1'b0, cand} + 5'(i);
      if (slot >= HOLES5) begin
        slot = slot - HOLES5;
      end
      if (!pick_found && !mole_positions[slot[3:0]]) begin
        pick_found               = 1'b1;
        pick_onehot[slot[3:0]]   = 1'b1;
      end
    end
  end

  assign spawn_fire   = (state_q == RUN) && ms_tick && (cnt_inc >= interval_eff) &&
                        (active_count < params.max_active) && pick_found;
  assign spawn_onehot = spawn_fire ? pick_onehot : '0;

  // Mirrors the per-hole timer updates so active_count lands with mole_positions.
  assign next_pos = (mole_positions & ~hit_now & ~miss_now) | spawn_onehot;

  always_comb begin
    next_count = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      next_count = next_count + 4'(next_pos[i]);
    end
  end

  for (genvar h = 0; h < N_HOLES; h++) begin : g_hole
    mole_hole_timer #(.MS_W(MS_W)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .ms_tick  (ms_tick),
      .load     (spawn_onehot[h]),
      .lifetime (params.lifetime),
      .kill     (hit_now[h]),
      .occupied (mole_positions[h]),
      .expire   (expire_vec[h])
    );
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop)  state_d = DRAIN;
      DRAIN: begin
        if (mole_positions == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      switches_q   <= '0;
      spawn_cnt    <= '0;
      hit_mask     <= '0;
      miss_mask    <= '0;
      active_count <= '0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      switches_q   <= switches;
      hit_mask     <= hit_now;
      miss_mask    <= miss_now;
      active_count <= next_count[1:0];
      done         <= done_d;
      if (state_q == IDLE && start) begin
        spawn_cnt <= '0;
      end else if (state_q == RUN && ms_tick) begin
        spawn_cnt <= spawn_fire ? '0 : cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_mole_spawn_scheduler.sv
// tb_mole_spawn_scheduler
// Self-checking bench for mole_spawn_scheduler (default build). A behavioural
// model tracks remaining life per hole in ms, the round state and the spawn
// pacing count; every cycle the DUT outputs are compared with it, and the
// scenario tasks add fixed-value checks for the documented corner cases.
module tb_mole_spawn_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ms_tick;
  logic        start;
  logic        stop;
  logic [2:0]  difficulty;
  logic [10:0] random_value;
  logic [8:0]  switches;
  logic [8:0]  mole_positions;
  logic [8:0]  hit_mask;
  logic [8:0]  miss_mask;
  logic [1:0]  active_count;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         m_life[9];
  int         m_state;
  int         m_cnt;
  logic [8:0] m_swq;
  logic [8:0] e_pos, e_hit, e_miss;
  int         e_active;
  logic       e_done;

  mole_spawn_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ms_tick        (ms_tick),
    .start          (start),
    .stop           (stop),
    .difficulty     (difficulty),
    .random_value   (random_value),
    .switches       (switches),
    .mole_positions (mole_positions),
    .hit_mask       (hit_mask),
    .miss_mask      (miss_mask),
    .active_count   (active_count),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] dut_vec();
    return {mole_positions, hit_mask, miss_mask, active_count, busy, done};
  endfunction

  function automatic logic [30:0] exp_vec();
    return {e_pos, e_hit, e_miss, 2'(e_active), (m_state != 0), e_done};
  endfunction

  task automatic get_params(input logic [2:0] d, output int iv, output int lt, output int ma);
    case (d)
      3'b001:  begin iv = 800; lt = 1500; ma = 1; end
      3'b010:  begin iv = 600; lt = 1200; ma = 2; end
      3'b100:  begin iv = 400; lt = 900;  ma = 3; end
      default: begin iv = 700; lt = 1300; ma = 1; end
    endcase
  endtask

  task automatic model_reset();
    for (int h = 0; h < 9; h++) m_life[h] = 0;
    m_state  = 0;
    m_cnt    = 0;
    m_swq    = '0;
    e_pos    = '0;
    e_hit    = '0;
    e_miss   = '0;
    e_active = 0;
    e_done   = 1'b0;
  endtask

  // One clock of game rules, evaluated on the inputs currently applied.
  task automatic model_step();
    int iv, lt, ma, live, c, pick, h;
    logic [8:0] occ, rise;
    get_params(difficulty, iv, lt, ma);
    occ  = '0;
    live = 0;
    for (int k = 0; k < 9; k++) begin
      if (m_life[k] > 0) begin
        occ[k] = 1'b1;
        live++;
      end
    end
    rise   = switches & ~m_swq;
    m_swq  = switches;
    e_hit  = (m_state != 0) ? (rise & occ) : '0;
    e_miss = '0;
    e_done = 1'b0;
    pick   = -1;
    if (m_state == 1 && ms_tick) begin
      m_cnt = m_cnt + 1;
      if (m_cnt > iv) m_cnt = iv;
      if (m_cnt >= iv && live < ma) begin
        c = int'(random_value[3:0]);
        if (c >= 9) c = c - 9;
        for (int k = 0; k < 9; k++) begin
          h = (c + k) % 9;
          if (pick < 0 && !occ[h]) pick = h;
        end
        m_cnt = 0;
      end
    end
    for (int k = 0; k < 9; k++) begin
      if (e_hit[k]) begin
        m_life[k] = 0;
      end else if (m_life[k] > 0 && ms_tick) begin
        m_life[k] = m_life[k] - 1;
        if (m_life[k] == 0) e_miss[k] = 1'b1;
      end
    end
    if (pick >= 0) m_life[pick] = lt;
    case (m_state)
      0: if (start) begin m_state = 1; m_cnt = 0; end
      1: if (stop) m_state = 2;
      default: if (live == 0) begin m_state = 0; e_done = 1'b1; end
    endcase
    e_pos    = '0;
    e_active = 0;
    for (int k = 0; k < 9; k++) begin
      if (m_life[k] > 0) begin
        e_pos[k] = 1'b1;
        e_active++;
      end
    end
  endtask

  task automatic step(input logic tick_i, input logic [8:0] sw_i, input logic [10:0] rv_i,
                      input logic start_i, input logic stop_i);
    ms_tick      = tick_i;
    switches     = sw_i;
    random_value = rv_i;
    start        = start_i;
    stop         = stop_i;
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] rv_low(input logic [3:0] low);
    logic [6:0] hi;
    hi = 7'($urandom);
    return {hi, low};
  endfunction

  task automatic do_reset();
    ms_tick      = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    switches     = '0;
    random_value = '0;
    reset_n      = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    difficulty = 3'b001;
    do_reset();
    checks++;
    if (dut_vec() !== 31'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", dut_vec(), 31'd0);
    end
    step(1'b1, 9'h000, 11'($urandom), 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL reset_idle_hold: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_easy_spawn_expire();
    difficulty = 3'b001;
    do_reset();
    step(1'b0, 9'h000, rv_low(4'd4), 1'b1, 1'b0);
    for (int i = 0; i < 800; i++) begin
      step(1'b1, 9'h000, rv_low(4'd4), 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL easy_wait tick %0d: got %h expected %h", i + 1, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (mole_positions !== 9'h010) begin
      errors++;
      $display("[TB] FAIL easy_spawn_hole: got %h expected %h", mole_positions, 9'h010);
    end
    for (int i = 0; i < 1500; i++) begin
      step(1'b1, 9'h000, 11'($urandom), 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL easy_life tick %0d: got %h expected %h", i + 1, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (miss_mask !== 9'h010 || mole_positions !== 9'h000) begin
      errors++;
      $display("[TB] FAIL easy_expire: got miss %h pos %h expected miss 010 pos 000", miss_mask, mole_positions);
    end
    step(1'b0, 9'h000, 11'($urandom), 1'b0, 1'b0);
    checks++;
    if (miss_mask !== 9'h000) begin
      errors++;
      $display("[TB] FAIL easy_miss_pulse: got %h expected %h", miss_mask, 9'h000);
    end
  endtask

  task automatic test_hard_probe();
    do_reset();
    difficulty = 3'b001;
    step(1'b0, 9'h000, 11'd0, 1'b1, 1'b0);
    for (int i = 0; i < 800; i++) step(1'b1, 9'h000, rv_low(4'd2), 1'b0, 1'b0);
    difficulty = 3'b010;
    for (int i = 0; i < 600; i++) step(1'b1, 9'h000, rv_low(4'd5), 1'b0, 1'b0);
    checks++;
    if (mole_positions !== 9'h024) begin
      errors++;
      $display("[TB] FAIL hard_setup: got %h expected %h", mole_positions, 9'h024);
    end
    difficulty = 3'b100;
    for (int i = 0; i < 400; i++) step(1'b1, 9'h000, rv_low(4'd2), 1'b0, 1'b0);
    checks++;
    if (mole_positions !== 9'h02C || active_count !== 2'd3) begin
      errors++;
      $display("[TB] FAIL hard_probe: got pos %h cnt %0d expected pos 02c cnt 3", mole_positions, active_count);
    end
    for (int i = 0; i < 499; i++) begin
      step(1'b1, 9'h000, rv_low(4'd0), 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL hard_capped tick %0d: got %h expected %h", i + 1, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (mole_positions !== 9'h02C || active_count !== 2'd3) begin
      errors++;
      $display("[TB] FAIL hard_blocked: got pos %h cnt %0d expected pos 02c cnt 3", mole_positions, active_count);
    end
    step(1'b1, 9'h000, rv_low(4'd0), 1'b0, 1'b0);
    checks++;
    if (mole_positions !== 9'h028 || miss_mask !== 9'h004) begin
      errors++;
      $display("[TB] FAIL hard_expire_no_reuse: got pos %h miss %h expected pos 028 miss 004", mole_positions, miss_mask);
    end
    step(1'b1, 9'h000, rv_low(4'd0), 1'b0, 1'b0);
    checks++;
    if (mole_positions !== 9'h029 || active_count !== 2'd3) begin
      errors++;
      $display("[TB] FAIL hard_deferred_spawn: got pos %h cnt %0d expected pos 029 cnt 3", mole_positions, active_count);
    end
  endtask

  task automatic test_hit_on_expire();
    difficulty = 3'b001;
    do_reset();
    step(1'b0, 9'h000, 11'd0, 1'b1, 1'b0);
    for (int i = 0; i < 800; i++) step(1'b1, 9'h000, rv_low(4'd5), 1'b0, 1'b0);
    for (int i = 0; i < 1499; i++) step(1'b1, 9'h000, 11'($urandom), 1'b0, 1'b0);
    checks++;
    if (mole_positions !== 9'h020) begin
      errors++;
      $display("[TB] FAIL hit_expire_setup: got %h expected %h", mole_positions, 9'h020);
    end
    step(1'b1, 9'h020, 11'($urandom), 1'b0, 1'b0);
    checks++;
    if (hit_mask !== 9'h020 || miss_mask !== 9'h000 || mole_positions !== 9'h000) begin
      errors++;
      $display("[TB] FAIL hit_beats_expire: got hit %h miss %h pos %h expected hit 020 miss 000 pos 000",
               hit_mask, miss_mask, mole_positions);
    end
    step(1'b0, 9'h000, 11'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_multi_hit();
    difficulty = 3'b100;
    do_reset();
    step(1'b0, 9'h000, 11'd0, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) step(1'b1, 9'h000, rv_low(4'd13), 1'b0, 1'b0);
    checks++;
    if (mole_positions !== 9'h010) begin
      errors++;
      $display("[TB] FAIL cand_wrap_13: got %h expected %h", mole_positions, 9'h010);
    end
    for (int i = 0; i < 400; i++) step(1'b1, 9'h000, rv_low(4'd9), 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) step(1'b1, 9'h000, rv_low(4'd3), 1'b0, 1'b0);
    checks++;
    if (mole_positions !== 9'h019) begin
      errors++;
      $display("[TB] FAIL multi_setup: got %h expected %h", mole_positions, 9'h019);
    end
    step(1'b0, 9'h009, 11'($urandom), 1'b0, 1'b0);
    checks++;
    if (hit_mask !== 9'h009 || mole_positions !== 9'h010 || active_count !== 2'd1) begin
      errors++;
      $display("[TB] FAIL multi_hit: got hit %h pos %h cnt %0d expected hit 009 pos 010 cnt 1",
               hit_mask, mole_positions, active_count);
    end
    step(1'b0, 9'h009, 11'($urandom), 1'b0, 1'b0);
    checks++;
    if (hit_mask !== 9'h000) begin
      errors++;
      $display("[TB] FAIL multi_hit_pulse: got %h expected %h", hit_mask, 9'h000);
    end
  endtask

  task automatic test_drain_done();
    difficulty = 3'b001;
    do_reset();
    step(1'b0, 9'h000, 11'd0, 1'b1, 1'b0);
    for (int i = 0; i < 800; i++) step(1'b1, 9'h000, rv_low(4'd4), 1'b0, 1'b0);
    step(1'b0, 9'h000, 11'd0, 1'b0, 1'b1);
    step(1'b0, 9'h000, 11'd0, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || mole_positions !== 9'h010) begin
      errors++;
      $display("[TB] FAIL drain_hold: got busy %b done %b pos %h expected busy 1 done 0 pos 010",
               busy, done, mole_positions);
    end
    step(1'b0, 9'h010, 11'd0, 1'b0, 1'b0);
    checks++;
    if (hit_mask !== 9'h010 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_whack: got hit %h busy %b done %b expected hit 010 busy 1 done 0",
               hit_mask, busy, done);
    end
    step(1'b0, 9'h010, 11'd0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_done: got done %b busy %b expected done 1 busy 0", done, busy);
    end
    step(1'b0, 9'h010, 11'd0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse: got %b expected %b", done, 1'b0);
    end
    step(1'b0, 9'h000, 11'd0, 1'b1, 1'b0);
    step(1'b0, 9'h000, 11'd0, 1'b0, 1'b1);
    step(1'b0, 9'h000, 11'd0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL empty_drain: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_run();
    difficulty = 3'b010;
    do_reset();
    step(1'b0, 9'h000, 11'd0, 1'b1, 1'b0);
    for (int i = 0; i < 1200; i++) step(1'b1, 9'h000, 11'($urandom), 1'b0, 1'b0);
    checks++;
    if (active_count !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_setup: got cnt %0d busy %b expected cnt 2 busy 1", active_count, busy);
    end
    reset_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (dut_vec() !== 31'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", dut_vec(), 31'd0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: got done %b busy %b expected 0 0", done, busy);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [2:0] codes[6];
    codes = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b011, 3'b111};
    difficulty = 3'b100;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) difficulty = codes[$urandom_range(5)];
      step(($urandom_range(3) != 0),
           9'($urandom) & 9'($urandom) & 9'($urandom),
           11'($urandom),
           ($urandom_range(49) == 0),
           ($urandom_range(299) == 0));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    ms_tick      = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    switches     = '0;
    random_value = '0;
    difficulty   = 3'b001;
    test_reset();
    test_easy_spawn_expire();
    test_hard_probe();
    test_hit_on_expire();
    test_multi_hit();
    test_drain_done();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
